div_sequencer: RTL

- Multi-cycle sequencer for the MIPS DIV/DIVU instruction. Sits beside the E stage.
- Accepts operands when a divide is in E and runs a radix-2 restoring division over WIDTH cycles.
- Drives the divstall input of the hazard unit, which holds F/D/E/M/W while busy.
- Delivers quotient (LO) and remainder (HI) to the hilo write path on completion.

---
 rtl/div_sequencer_pkg.sv | 17 +
 rtl/div_sequencer_if.sv | 24 ++
 rtl/div_sequencer_step.sv | 22 ++
 rtl/div_sequencer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the DIV/DIVU sequencer: default width and FSM state encoding.
package div_sequencer_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  // state | meaning
  // IDLE  | waiting for a divide in E; accepts operands
  // BUSY  | one quotient bit per cycle, pipeline stalled
  // DONE  | result registers valid, one-cycle div_done pulse
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_sequencer_if.sv
// E-stage side of the divider: operand hand-off, stall and result delivery.
interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             div_startE;
  logic             div_signedE;
  logic [WIDTH-1:0] opaE;
  logic [WIDTH-1:0] opbE;
  logic             annul;
  logic             div_stall;
  logic             div_done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output div_startE, div_signedE, opaE, opbE, annul,
    input  div_stall, div_done, hi_out, lo_out
  );

  modport slave (
    input  div_startE, div_signedE, opaE, opbE, annul,
    output div_stall, div_done, hi_out, lo_out
  );
endinterface

// File: rtl/div_sequencer_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] shifted;
  logic           fits;

  // The shifted remainder needs WIDTH+1 bits; a fitting difference is below the
  // divisor, so the low WIDTH bits of the modular subtract are exact.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    fits    = (shifted >= {1'b0, divisor_i});
    rem_o   = fits ? (shifted[WIDTH-1:0] - divisor_i) : shifted[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], fits};
  end
endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer beside the E stage; stalls the pipeline while busy.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  div_sequencer_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             negq_q, negq_d, negr_q, negr_d;
  logic [WIDTH-1:0] rem_step, quo_step, abs_a, abs_b;
  logic             a_neg, b_neg, accept, stall, done;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (rem_step),
    .quo_o     (quo_step)
  );

  assign a_neg  = bus.div_signedE & bus.opaE[WIDTH-1];
  assign b_neg  = bus.div_signedE & bus.opbE[WIDTH-1];
  assign abs_a  = a_neg ? -bus.opaE : bus.opaE;
  assign abs_b  = b_neg ? -bus.opbE : bus.opbE;
  assign accept = bus.div_startE & ~bus.annul;

  // State and datapath registers; reset wins over any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  // Next-state, datapath update and stall/done outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    stall   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          stall  = 1'b1;
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
          rem_d  = '0;
          quo_d  = abs_a;
          dvs_d  = abs_b;
          cnt_d  = '0;
          if (bus.opbE == '0) begin
            // Divide by zero skips the iterations with a fixed result.
            state_d = DONE;
            lo_d    = '1;
            hi_d    = bus.opaE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus.annul) begin
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = DONE;
            lo_d    = negq_q ? -quo_step : quo_step;
            hi_d    = negr_q ? -rem_step : rem_step;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.div_stall = stall;
  assign bus.div_done  = done;
  assign bus.hi_out    = hi_q;
  assign bus.lo_out    = lo_q;
endmodule
